// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared definitions for the half-integer clock divider controller and its core.
//   state_t   : controller states (IDLE, RUN, DRAIN, STOP)
//   MIN_RATIO : smallest legal ratio code R (divide factor R/2)
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    STOP
  } state_t;

  localparam int MIN_RATIO = 4;

endpackage

// File: rtl/clk_div_frac_core.sv
// clk_div_frac_core
//   Half-integer divider core. A window is R clk_in cycles (2R half-cycles, two output
//   periods). Each period is R half-cycles long and high for floor(R/2) half-cycles.
// Ports
//   clk_in  in   source clock (counter on posedge, one phase flop on negedge)
//   rst     in   asynchronous active-high reset
//   ratio   in   ratio code R applied to the current window (held stable within a window)
//   run     in   core produces a window next cycle
//   restart in   next cycle is cycle 0 of a fresh window (controller leaving IDLE)
//   wrap    out  last cycle of the current window
//   clk_out out  divided clock
module clk_div_frac_core
  import clk_div_pkg::*;
#(
  parameter int RATIO_W = 6
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               run,
  input  logic               restart,
  output logic               wrap,
  output logic               clk_out
);

  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] cnt_next;
  logic               run_q;
  logic               pos_hi;
  logic               neg_hi;

  // Each phase flop holds its value for two half-cycles, so clk_out is the OR of the
  // two flops. Storing "high and the following half is also high" (index < floor(R/2)-1)
  // makes the OR reproduce exactly floor(R/2) high half-cycles per period without
  // ever muxing on the clock itself.
  function automatic logic lead_high(input logic [RATIO_W:0] h, input logic [RATIO_W-1:0] r);
    logic [RATIO_W:0] r_ext;
    logic [RATIO_W:0] h_mod;
    logic [RATIO_W:0] lim;
    r_ext = {1'b0, r};
    h_mod = (h >= r_ext) ? (h - r_ext) : h;
    lim   = {2'b00, r[RATIO_W-1:1]} - 1'b1;
    return h_mod < lim;
  endfunction

  assign wrap    = run_q && (cnt == ratio - 1'b1);
  assign clk_out = pos_hi | neg_hi;

  // Counter restarts at 0 for a fresh window or after the last cycle of a window.
  always_comb begin
    cnt_next = '0;
    if (run && !restart && !wrap) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Posedge phase: covers even half-cycle h = 2*cnt of the cycle being entered.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      run_q  <= 1'b0;
      pos_hi <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      run_q  <= run;
      pos_hi <= run && lead_high({cnt_next, 1'b0}, ratio);
    end
  end

  // Negedge phase: covers odd half-cycle h = 2*cnt+1 of the current cycle.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      neg_hi <= 1'b0;
    end else begin
      neg_hi <= run_q && lead_high({cnt, 1'b1}, ratio);
    end
  end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// clk_div_ratio_ctrl
//   Runtime controller for the half-integer clock divider. Holds the active ratio code,
//   accepts new codes over a valid/ready port and applies them only at a window boundary,
//   and starts/stops the divided clock only on window boundaries.
// Ports
//   clk_in    in   source clock
//   rst       in   asynchronous active-high reset
//   en        in   1 = run divided clock, 0 = stop at next window boundary
//   cfg_valid in   new ratio request
//   cfg_ratio in   requested ratio code R (divide factor R/2)
//   cfg_ready out  request can be accepted (IDLE, RUN)
//   cfg_err   out  one-cycle pulse after an accepted request with R < MIN_RATIO
//   busy      out  ratio change pending (DRAIN)
//   cur_ratio out  ratio code currently applied
//   clk_out   out  divided clock
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_W     = 6,
  parameter int RESET_RATIO = 9
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               busy,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               clk_out
);

  localparam logic [RATIO_W-1:0] MIN_CODE   = RATIO_W'(MIN_RATIO);
  localparam logic [RATIO_W-1:0] RESET_CODE = RATIO_W'(RESET_RATIO);

  state_t             state;
  state_t             state_next;
  logic [RATIO_W-1:0] pending;
  logic [RATIO_W-1:0] pending_next;
  logic [RATIO_W-1:0] cur_next;
  logic               err_next;
  logic               xfer;
  logic               legal;
  logic               wrap;
  logic               core_run;
  logic               core_restart;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state == DRAIN);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_ratio >= MIN_CODE);

  // The core runs whenever the controller will be outside IDLE next cycle, so a window
  // starts on the same posedge that sees en=1 in IDLE. A legal request in RUN takes
  // priority over en=0; the DRAIN exit then decides between RUN and IDLE.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    cur_next     = cur_ratio;
    err_next     = xfer && !legal;
    case (state)
      IDLE: begin
        if (xfer && legal) begin
          cur_next = cfg_ratio;
        end
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (xfer && legal) begin
          pending_next = cfg_ratio;
          state_next   = DRAIN;
        end else if (!en) begin
          state_next = wrap ? IDLE : STOP;
        end
      end
      DRAIN: begin
        if (wrap) begin
          cur_next   = pending;
          state_next = en ? RUN : IDLE;
        end
      end
      STOP: begin
        if (wrap) begin
          state_next = en ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign core_run     = (state_next != IDLE);
  assign core_restart = (state == IDLE);

  // Controller registers; reset discards any pending request.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= RESET_CODE;
      cur_ratio <= RESET_CODE;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      cur_ratio <= cur_next;
      cfg_err   <= err_next;
    end
  end

  clk_div_frac_core #(
    .RATIO_W(RATIO_W)
  ) u_core (
    .clk_in (clk_in),
    .rst    (rst),
    .ratio  (cur_ratio),
    .run    (core_run),
    .restart(core_restart),
    .wrap   (wrap),
    .clk_out(clk_out)
  );

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb_clk_div_ratio_ctrl
//   Self-checking bench for clk_div_ratio_ctrl. A behavioural model tracks the window
//   position, applied ratio, pending request and stop request, and predicts clk_out from
//   the half-cycle rule (h mod R) < floor(R/2) in both halves of every clk_in cycle.
module tb_clk_div_ratio_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [5:0] cfg_ratio;
  logic       cfg_ready;
  logic       cfg_err;
  logic       busy;
  logic [5:0] cur_ratio;
  logic       clk_out;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_running;
  bit m_stop;
  bit m_pend_v;
  bit m_err;
  int m_pos;
  int m_ratio;
  int m_pend;

  logic        exp_pos;
  logic        exp_neg;
  logic        obs_pos;
  logic [10:0] exp_vec;
  logic [10:0] obs_vec;

  // 10 ns source clock
  always #5 clk_in = ~clk_in;

  clk_div_ratio_ctrl #(
    .RATIO_W(6),
    .RESET_RATIO(9)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ratio(cfg_ratio),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .cur_ratio(cur_ratio),
    .clk_out  (clk_out)
  );

  // Output level for half-cycle h of a period of r half-cycles
  function automatic logic wave_at(input int h, input int r);
    return (h % r) < (r / 2);
  endfunction

  task automatic model_reset();
    m_running = 0;
    m_stop    = 0;
    m_pend_v  = 0;
    m_err     = 0;
    m_pos     = 0;
    m_ratio   = 9;
    m_pend    = 0;
  endtask

  // Advance the model by one clk_in cycle using the inputs seen at the posedge
  task automatic model_advance(input bit in_en, input bit in_valid, input int in_r);
    bit ready;
    bit xfer;
    bit legal_new;
    bit keep;
    ready     = !m_pend_v && !m_stop;
    xfer      = in_valid && ready;
    legal_new = xfer && (in_r >= 4);
    m_err     = xfer && (in_r < 4);
    if (!m_running) begin
      if (legal_new) m_ratio = in_r;
      if (in_en) begin
        m_running = 1;
        m_pos     = 0;
      end
    end else if (m_pos == m_ratio - 1) begin
      keep = in_en;
      if (m_pend_v) begin
        m_ratio  = m_pend;
        m_pend_v = 0;
      end else if (m_stop) begin
        m_stop = 0;
      end else if (legal_new) begin
        m_pend   = in_r;
        m_pend_v = 1;
        keep     = 1;
      end
      m_pos     = 0;
      m_running = keep;
    end else begin
      m_pos++;
      if (legal_new) begin
        m_pend   = in_r;
        m_pend_v = 1;
      end else if (ready && !in_en) begin
        m_stop = 1;
      end
    end
    exp_pos = m_running ? wave_at(2 * m_pos, m_ratio) : 1'b0;
    exp_neg = m_running ? wave_at(2 * m_pos + 1, m_ratio) : 1'b0;
    exp_vec = {exp_pos, exp_neg, 6'(m_ratio), m_pend_v, !m_pend_v && !m_stop, m_err};
  endtask

  // One clk_in cycle: model update at posedge, DUT sampled 2 ns into each half
  task automatic step();
    @(posedge clk_in);
    model_advance(en, cfg_valid, int'(cfg_ratio));
    #2;
    obs_pos = clk_out;
    @(negedge clk_in);
    #2;
    obs_vec = {obs_pos, clk_out, cur_ratio, busy, cfg_ready, cfg_err};
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ratio = 6'd0;
    model_reset();
    repeat (10) @(negedge clk_in);
    #2;
    n_cmp++;
    if (clk_out !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_clk_out got %b want 0", clk_out);
    end
    n_cmp++;
    if (cur_ratio !== 6'd9) begin
      n_bad++;
      $display("[TB] FAIL reset_cur_ratio got %0d want 9", cur_ratio);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_cfg_ready got %b want 1", cfg_ready);
    end
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_cfg_err got %b want 0", cfg_err);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_bad++;
      $display("[TB] FAIL idle_after_reset got %h want %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_run_r9();
    en = 1'b1;
    for (int i = 0; i < 27; i++) begin
      step();
      if (i == 0) begin
        n_cmp++;
        if (obs_pos !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL first_rise got %b want 1", obs_pos);
        end
      end
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL run_r9 cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_illegal();
    step();
    cfg_valid = 1'b1;
    cfg_ratio = 6'd3;
    step();
    cfg_valid = 1'b0;
    cfg_ratio = 6'd17;
    n_cmp++;
    if (cfg_err !== 1'b1 || cur_ratio !== 6'd9) begin
      n_bad++;
      $display("[TB] FAIL illegal_pulse got err=%b ratio=%0d want err=1 ratio=9", cfg_err, cur_ratio);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL illegal_follow cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_ratio_change();
    cfg_valid = 1'b1;
    cfg_ratio = 6'd8;
    step();
    cfg_valid = 1'b0;
    cfg_ratio = 6'd5;
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL change_accept got busy=%b ready=%b want busy=1 ready=0", busy, cfg_ready);
    end
    for (int i = 0; i < 30 && m_pend_v; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL change_drain cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || cur_ratio !== 6'd8) begin
      n_bad++;
      $display("[TB] FAIL change_done got busy=%b ratio=%0d want busy=0 ratio=8", busy, cur_ratio);
    end
    for (int i = 0; i < 24; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL change_r8 cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_stop_idle();
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 40 && m_running; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL stop_drain cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (clk_out !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stop_idle got clk_out=%b ready=%b want 0/1", clk_out, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_ratio = 6'd12;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cur_ratio !== 6'd12) begin
      n_bad++;
      $display("[TB] FAIL idle_load got %0d want 12", cur_ratio);
    end
    en = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL run_r12 cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_simultaneous();
    step();
    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_ratio = 6'd10;
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_bad++;
      $display("[TB] FAIL simul_accept got %h want %h", obs_vec, exp_vec);
    end
    for (int i = 0; i < 40 && m_running; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL simul_drain cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (cur_ratio !== 6'd10 || clk_out !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL simul_done got ratio=%0d clk_out=%b busy=%b want 10/0/0", cur_ratio, clk_out, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ratio = 6'($urandom_range(0, 20));
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL random cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 0;
    en    = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("[TB] FAIL pre_reset cycle %0d got %h want %h", i, obs_vec, exp_vec);
      end
      found = (exp_neg === 1'b1);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (clk_out !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_clk_out got %b want 0", clk_out);
    end
    n_cmp++;
    if (cur_ratio !== 6'd9 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL async_state got ratio=%0d busy=%b ready=%b want 9/0/1", cur_ratio, busy, cfg_ready);
    end
    model_reset();
    en = 1'b0;
    @(negedge clk_in);
    #2;
    rst = 1'b0;
    step();
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_bad++;
      $display("[TB] FAIL after_async got %h want %h", obs_vec, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_run_r9();
    test_illegal();
    test_ratio_change();
    test_stop_idle();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
